dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the single-port data memory (sync write, async read).

---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for a single-port data memory (sync write, async read).
// Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic              o_err0,
    output logic              o_err1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_memread,
    output logic              o_mem_memwrite,
    input  logic [DATA_W-1:0] i_mem_read_data
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_win;
    logic                r_win;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic                r_err0;
    logic                r_err1;
    logic                w_any;
    logic                w_pick1;
    logic                w_mis;

    assign w_any = i_req0 | i_req1;
    assign w_mis = |r_addr[1:0];
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_pick1 = !i_req0;
`else
    assign w_pick1 = (i_req0 && i_req1) ? !r_last_win : i_req1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_any) w_next = ACCESS;
        if (r_state == ACCESS)        w_next = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_win <= 1'b1;
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_win   <= w_pick1;
                r_we    <= w_pick1 ? i_we1 : i_we0;
                r_addr  <= w_pick1 ? i_addr1 : i_addr0;
                r_wdata <= w_pick1 ? i_wdata1 : i_wdata0;
            end
            if (r_state == ACCESS) begin
                r_rvalid0  <= !r_win;
                r_rvalid1  <= r_win;
                r_err0     <= !r_win && w_mis;
                r_err1     <= r_win && w_mis;
                r_last_win <= r_win;
                if (!r_we) r_rdata <= i_mem_read_data;
            end
        end
    end

    // Memory command outputs hold their last value outside ACCESS; strobes do not.
    assign o_gnt0           = (r_state == ACCESS) && !r_win;
    assign o_gnt1           = (r_state == ACCESS) && r_win;
    assign o_rvalid0        = r_rvalid0;
    assign o_rvalid1        = r_rvalid1;
    assign o_err0           = r_err0;
    assign o_err1           = r_err1;
    assign o_rdata          = r_rdata;
    assign o_mem_addr       = r_addr;
    assign o_mem_write_data = r_wdata;
    assign o_mem_memread    = (r_state == ACCESS) && !r_we;
    assign o_mem_memwrite   = (r_state == ACCESS) && r_we && !w_mis && !i_reset;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural data memory.
// Build with +define+DMEM_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata, mem_write_data, mem_read_data;
    logic [7:0]  mem_addr;
    logic        mem_memread, mem_memwrite;
    logic [31:0] mem [64];
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_err0(err0), .o_err1(err1), .o_rdata(rdata),
        .o_mem_addr(mem_addr), .o_mem_write_data(mem_write_data),
        .o_mem_memread(mem_memread), .o_mem_memwrite(mem_memwrite),
        .i_mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;
    always @(posedge clk) if (mem_memwrite) mem[mem_addr[7:2]] <= mem_write_data;
    assign mem_read_data = mem[mem_addr[7:2]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction on port p; returns grant/strobe snapshots for the ACCESS and done cycles.
    task automatic run(input int p, input logic we, input logic [7:0] a, input logic [31:0] d,
                       output logic [1:0] g, output logic mw, output logic [1:0] v,
                       output logic [1:0] e, output logic [31:0] rd);
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        tick;
        g  = {gnt1, gnt0};
        mw = mem_memwrite;
        req0 = 1'b0;
        req1 = 1'b0;
        tick;
        v  = {rvalid1, rvalid0};
        e  = {err1, err0};
        rd = rdata;
    endtask

    task automatic test_reset;
        logic [83:0] obs;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        obs = {gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata, mem_addr, mem_write_data,
               mem_memread, mem_memwrite};
        n_cmp++;
        if (obs !== 84'd0) begin n_bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    endtask

    task automatic test_write_read;
        logic [1:0] g, v, e;
        logic mw;
        logic [31:0] rd;
        run(0, 1'b1, 8'h04, 32'hDEADBEEF, g, mw, v, e, rd);
        n_cmp++;
        if ({g, mw, v, e} !== 7'b01_1_01_00) begin
            n_bad++; $display("FAIL wr04 got g=%b mw=%b v=%b e=%b want g=01 mw=1 v=01 e=00", g, mw, v, e);
        end
        run(0, 1'b0, 8'h04, 32'h0, g, mw, v, e, rd);
        n_cmp++;
        if ({g, mw, v, e} !== 7'b01_0_01_00) begin
            n_bad++; $display("FAIL rd04_ctl got g=%b mw=%b v=%b e=%b want g=01 mw=0 v=01 e=00", g, mw, v, e);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd04_data got=%h want=deadbeef", rd); end
    endtask

    task automatic test_arbitration;
        logic [1:0] g, v, e;
        logic mw;
        logic [31:0] rd;
        logic [1:0] want;
        run(1, 1'b1, 8'h00, 32'h11112222, g, mw, v, e, rd);
        n_cmp++;
        if ({g, mw, v} !== 5'b10_1_10) begin
            n_bad++; $display("FAIL wr00_p1 got g=%b mw=%b v=%b want g=10 mw=1 v=10", g, mw, v);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h04;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h00;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            want = 2'b01;
`else
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            tick;
            n_cmp++;
            if ({gnt1, gnt0} !== want) begin
                n_bad++; $display("FAIL rr_gnt%0d got=%b want=%b", i, {gnt1, gnt0}, want);
            end
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
            tick;
            n_cmp++;
            if ({rvalid1, rvalid0} !== want) begin
                n_bad++; $display("FAIL rr_rvalid%0d got=%b want=%b", i, {rvalid1, rvalid0}, want);
            end
            n_cmp++;
            if (rdata !== (want[0] ? 32'hDEADBEEF : 32'h11112222)) begin
                n_bad++; $display("FAIL rr_rdata%0d got=%h want=%h", i, rdata,
                                  want[0] ? 32'hDEADBEEF : 32'h11112222);
            end
        end
        tick;
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b00) begin n_bad++; $display("FAIL rr_idle got=%b want=00", {gnt1, gnt0}); end
    endtask

    task automatic test_misaligned;
        logic [1:0] g, v, e;
        logic mw;
        logic [31:0] rd;
        run(1, 1'b1, 8'h09, 32'h12345678, g, mw, v, e, rd);
        n_cmp++;
        if ({g, mw, v, e} !== 7'b10_0_10_10) begin
            n_bad++; $display("FAIL mis_wr got g=%b mw=%b v=%b e=%b want g=10 mw=0 v=10 e=10", g, mw, v, e);
        end
        run(1, 1'b0, 8'h08, 32'h0, g, mw, v, e, rd);
        n_cmp++;
        if ({e, rd} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL mis_rd08 got e=%b rd=%h want e=00 rd=00000000", e, rd);
        end
        run(0, 1'b0, 8'h05, 32'h0, g, mw, v, e, rd);
        n_cmp++;
        if ({v, e, rd} !== {2'b01, 2'b01, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL mis_rd05 got v=%b e=%b rd=%h want v=01 e=01 rd=deadbeef", v, e, rd);
        end
    endtask

    task automatic test_reset_mid_access;
        logic [83:0] obs;
        logic [1:0] g, v, e;
        logic mw;
        logic [31:0] rd;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hAAAA5555;
        tick;
        req0 = 1'b0;
        n_cmp++;
        if ({gnt0, mem_memwrite} !== 2'b11) begin
            n_bad++; $display("FAIL rst_pre got gnt0=%b mw=%b want 1 1", gnt0, mem_memwrite);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_memwrite !== 1'b0) begin n_bad++; $display("FAIL rst_mw got=%b want=0", mem_memwrite); end
        tick;
        reset = 1'b0;
        obs = {gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata, mem_addr, mem_write_data,
               mem_memread, mem_memwrite};
        n_cmp++;
        if (obs !== 84'd0) begin n_bad++; $display("FAIL rst_outputs got=%h want=0", obs); end
        run(0, 1'b0, 8'h10, 32'h0, g, mw, v, e, rd);
        n_cmp++;
        if ({v, rd} !== {2'b01, 32'h0}) begin
            n_bad++; $display("FAIL rst_rd10 got v=%b rd=%h want v=01 rd=00000000", v, rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] g, v, e;
        logic mw;
        logic [31:0] rd;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h00; wdata0 = 32'hC0DE0000;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++;
            if ({gnt0, mem_memwrite} !== 2'b11) begin
                n_bad++; $display("FAIL b2b_acc%0d got gnt0=%b mw=%b want 1 1", i, gnt0, mem_memwrite);
            end
            if (i == 3) req0 = 1'b0;
            addr0 = 8'((i + 1) * 4);
            wdata0 = 32'hC0DE0000 + 32'(i + 1);
            tick;
            n_cmp++;
            if ({gnt0, mem_memwrite, rvalid0} !== 3'b001) begin
                n_bad++; $display("FAIL b2b_idle%0d got gnt0=%b mw=%b rv0=%b want 0 0 1", i, gnt0,
                                  mem_memwrite, rvalid0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            run(0, 1'b0, 8'(i * 4), 32'h0, g, mw, v, e, rd);
            n_cmp++;
            if (rd !== 32'hC0DE0000 + 32'(i)) begin
                n_bad++; $display("FAIL b2b_rd%0d got=%h want=%h", i, rd, 32'hC0DE0000 + 32'(i));
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_arbitration;
        test_misaligned;
        test_reset_mid_access;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
